// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// axi_mem_slave : AXI4 INCR-burst slave over a 2**MEM_AW x 64-bit memory
// Rev 1.0 - initial release
// ============================================================================
module axi_mem_slave #(
  parameter int ID_WIDTH = 4,
  parameter int MEM_AW   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [29:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [63:0]         s_axi_wdata,
  input  logic [7:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [29:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [63:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [63:0] mem [DEPTH];

  logic [ID_WIDTH-1:0] w_id;
  logic [MEM_AW-1:0]   w_idx;
  logic [7:0]          w_len, w_cnt;
  logic                w_burst_err, w_last_err;
  logic                w_beat, w_final;

  logic [MEM_AW-1:0]   r_idx, r_idx_next, ar_idx;
  logic [7:0]          r_len, r_cnt;
  logic                r_err;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[29:MEM_AW+3], s_axi_awaddr[2:0],
                              s_axi_araddr[29:MEM_AW+3], s_axi_araddr[2:0]};

  assign w_beat     = (w_state == W_DATA) && s_axi_wvalid;
  assign w_final    = (w_cnt == w_len);
  assign s_axi_bid  = w_id;
  assign ar_idx     = s_axi_araddr[MEM_AW+2:3];
  assign r_idx_next = r_idx + MEM_AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id        <= '0;
      w_idx       <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_burst_err <= 1'b0;
      w_last_err  <= 1'b0;
      s_axi_bresp <= 2'b00;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        w_id        <= s_axi_awid;
        w_idx       <= s_axi_awaddr[MEM_AW+2:3];
        w_len       <= s_axi_awlen;
        w_cnt       <= '0;
        w_burst_err <= (s_axi_awburst != 2'b01);
        w_last_err  <= 1'b0;
      end
      if (w_beat) begin
        w_idx <= w_idx + MEM_AW'(1);
        w_cnt <= w_cnt + 8'd1;
        if (s_axi_wlast != w_final) w_last_err <= 1'b1;
        // The beat count, not wlast, ends the burst; a wlast mismatch only flags the response.
        if (w_final)
          s_axi_bresp <= (w_burst_err || w_last_err || (s_axi_wlast != w_final)) ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat && !w_burst_err) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // Non-blocking memory update means a same-cycle fetch sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      s_axi_rlast <= 1'b0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rid   <= s_axi_arid;
      s_axi_rdata <= (s_axi_arburst == 2'b01) ? mem[ar_idx] : 64'd0;
      s_axi_rresp <= (s_axi_arburst == 2'b01) ? 2'b00 : 2'b10;
      s_axi_rlast <= (s_axi_arlen == 8'd0);
      r_idx       <= ar_idx;
      r_len       <= s_axi_arlen;
      r_cnt       <= '0;
      r_err       <= (s_axi_arburst != 2'b01);
    end else if (s_axi_rvalid && s_axi_rready) begin
      if (!s_axi_rlast) begin
        r_idx       <= r_idx_next;
        r_cnt       <= r_cnt + 8'd1;
        s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
        s_axi_rdata <= r_err ? 64'd0 : mem[r_idx_next];
      end else begin
        s_axi_rlast <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// tb_axi_mem_slave : scoreboard bench for the AXI memory slave.
module tb_axi_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [29:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b1, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;
  logic [63:0] wdata = '0, rdata;

  axi_mem_slave #(.ID_WIDTH(4), .MEM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {logic [63:0] data; logic last; logic [3:0] id; logic [1:0] resp;} rbeat_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];
  rbeat_t re;
  bexp_t  be;

  logic [63:0] mdl [0:4095];
  logic [63:0] wd  [0:255];
  logic [7:0]  ws  [0:255];
  logic [3:0]  rr_pat = 4'b1111;

  logic        stall_prev = 1'b0;
  logic [63:0] prev_d = '0;
  logic        prev_l = 1'b0;

  // Output monitor: pops the scoreboard on every handshake, checks holds during stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rvalid && stall_prev) begin
        check("r_hold_data", rdata, prev_d);
        check("r_hold_last", rlast, prev_l);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected_beat", 1, 0);
        else begin
          re = rq.pop_front();
          check("rdata", rdata, re.data);
          check("rlast", rlast, re.last);
          check("rid", rid, re.id);
          check("rresp", rresp, re.resp);
        end
      end
      stall_prev = rvalid && !rready;
      prev_d     = rdata;
      prev_l     = rlast;
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          check("bid", bid, be.id);
          check("bresp", bresp, be.resp);
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] id, input logic [29:0] addr, input int len,
                           input logic [1:0] burst, input int bad_last);
    logic [11:0] idx;
    bexp_t       t;
    int          n;
    t.id   = id;
    t.resp = (burst != 2'b01 || bad_last >= 0) ? 2'b10 : 2'b00;
    bq.push_back(t);
    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len[7:0]; awburst = burst;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("aw_ready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    idx = addr[14:3];
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast  = (bad_last >= 0) ? (i == bad_last) : (i == len);
      @(negedge clk);
      if (!wready) check("w_ready", wready, 1);
      if (burst == 2'b01)
        for (int b = 0; b < 8; b++) if (ws[i][b]) mdl[idx][8*b +: 8] = wd[i][8*b +: 8];
      idx++;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("b_latency", bvalid, 1);
    n = 0;
    while (bq.size() > 0 && n < 20) begin @(negedge clk); n++; end
    check("b_drain", bq.size(), 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [29:0] addr, input int len,
                          input logic [1:0] burst);
    logic [11:0] idx;
    rbeat_t      t;
    int          n;
    idx = addr[14:3];
    for (int i = 0; i <= len; i++) begin
      t.data = (burst == 2'b01) ? mdl[idx] : 64'd0;
      t.last = (i == len);
      t.id   = id;
      t.resp = (burst == 2'b01) ? 2'b00 : 2'b10;
      rq.push_back(t);
      idx++;
    end
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len[7:0]; arburst = burst;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("ar_ready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (rq.size() > 0 && n < 4 * len + 40) begin
      rready = rr_pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    check("r_drain", rq.size(), 0);
    @(negedge clk);
    check("arready_after_read", arready, 1);
  endtask

  initial begin
    #1;
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic 4-beat write and readback.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(4'd3, 30'h40, 3, 2'b01, -1);
    axi_read(4'd5, 30'h40, 3, 2'b01);

    // Partial strobe merge.
    wd[0] = 64'h1111_1111_1111_1111; ws[0] = 8'hFF;
    axi_write(4'd1, 30'h100, 0, 2'b01, -1);
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'h0F;
    axi_write(4'd1, 30'h100, 0, 2'b01, -1);
    axi_read(4'd2, 30'h100, 0, 2'b01);

    // 8-beat read with rready stalls, ID echoed from the write.
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(4'd9, 30'h400, 7, 2'b01, -1);
    rr_pat = 4'b1001;
    axi_read(4'd9, 30'h400, 7, 2'b01);
    rr_pat = 4'b1111;

    // Non-INCR write with early wlast: SLVERR, memory untouched.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'h5000 + 64'(i); ws[i] = 8'hFF; end
    axi_write(4'd4, 30'h300, 3, 2'b01, -1);
    for (int i = 0; i < 4; i++) wd[i] = 64'hDEAD_0000 + 64'(i);
    axi_write(4'd6, 30'h300, 3, 2'b10, 1);
    axi_read(4'd6, 30'h300, 3, 2'b01);

    // INCR write with early wlast only: SLVERR response.
    axi_write(4'd7, 30'h380, 3, 2'b01, 1);
    axi_read(4'd7, 30'h380, 3, 2'b01);

    // Non-INCR read: zero data, SLVERR on every beat.
    axi_read(4'd8, 30'h40, 2, 2'b00);

    // Burst starting at the top word wraps to index 0.
    wd[0] = 64'hF0F0_0000_0000_0FFF; wd[1] = 64'h0BAD_CAFE_0000_0000;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(4'd10, 30'h7FF8, 1, 2'b01, -1);
    axi_read(4'd11, 30'h7FF8, 1, 2'b01);
    axi_read(4'd12, 30'h0, 0, 2'b01);

    // Full 256-beat burst.
    for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
    axi_write(4'd13, 30'h2000, 255, 2'b01, -1);
    axi_read(4'd14, 30'h2000, 255, 2'b01);

    // Asynchronous reset in the middle of a stalled read.
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 4'd15; araddr = 30'h40; arlen = 8'd7; arburst = 2'b01;
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    check("pre_reset_rvalid", rvalid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", rvalid, 0);
    check("async_rst_arready", arready, 1);
    check("async_rst_rlast", rlast, 0);
    check("async_rst_rid", rid, 0);
    check("async_rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Memory contents survive reset.
    axi_read(4'd1, 30'h40, 3, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter MEM_AW, default 12, word-address width; depth 2**MEM_AW 64-bit words.
REQ-003 SHALL have clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have s_axi_awid  input  ID_WIDTH  write burst ID.
REQ-006 SHALL have s_axi_awaddr  input  30  write byte address.
REQ-007 SHALL have s_axi_awlen  input  8  write beats minus one.
REQ-008 SHALL have s_axi_awburst  input  2  burst type.
REQ-009 SHALL have s_axi_awvalid  input  1  write address valid.
REQ-010 SHALL have s_axi_awready  output  1  write address ready.
REQ-011 SHALL have s_axi_wdata  input  64  write data.
REQ-012 SHALL have s_axi_wstrb  input  8  byte enables.
REQ-013 SHALL have s_axi_wlast  input  1  final write beat.
REQ-014 SHALL have s_axi_wvalid  input  1  write data valid.
REQ-015 SHALL have s_axi_wready  output  1  write data ready.
REQ-016 SHALL have s_axi_bid  output  ID_WIDTH  response ID.
REQ-017 SHALL have s_axi_bresp  output  2  write response.
REQ-018 SHALL have s_axi_bvalid  output  1  response valid.
REQ-019 SHALL have s_axi_bready  input  1  response ready.
REQ-020 SHALL have s_axi_arid  input  ID_WIDTH  read burst ID.
REQ-021 SHALL have s_axi_araddr  input  30  read byte address.
REQ-022 SHALL have s_axi_arlen  input  8  read beats minus one.
REQ-023 SHALL have s_axi_arburst  input  2  burst type.
REQ-024 SHALL have s_axi_arvalid  input  1  read address valid.
REQ-025 SHALL have s_axi_arready  output  1  read address ready.
REQ-026 SHALL have s_axi_rid  output  ID_WIDTH  read data ID.
REQ-027 SHALL have s_axi_rdata  output  64  read data.
REQ-028 SHALL have s_axi_rresp  output  2  read response.
REQ-029 SHALL have s_axi_rlast  output  1  final read beat.
REQ-030 SHALL have s_axi_rvalid  output  1  read data valid.
REQ-031 SHALL have s_axi_rready  input  1  read data ready.

Function
REQ-032 SHALL decode word index = addr[MEM_AW+2:3], ignore addr[2:0], treat every beat as 8 bytes, increment index by 1 per beat modulo 2**MEM_AW.
REQ-033 SHALL run independent write FSM W_IDLE/W_DATA/W_RESP: awready=1 only in W_IDLE; AW handshake captures ID, index, awlen, burst-error flag -> W_DATA.
REQ-034 SHALL in W_DATA hold wready=1; each wvalid&wready beat writes bytes with wstrb[i]=1 only, then index+1; beat count==awlen -> W_RESP.
REQ-035 SHALL in W_RESP hold bvalid=1, bid=captured ID; stay until bready, then W_IDLE; min latency last W beat -> bvalid = 1 cycle.
REQ-036 SHALL bresp=2'b00, except 2'b10 (SLVERR) if awburst!=2'b01 (no memory writes in that burst, all beats accepted) or wlast disagrees with count==awlen on any beat.
REQ-037 SHALL run read FSM R_IDLE/R_DATA: arready=1 only in R_IDLE; AR handshake registers rdata<=mem[index], rid, rvalid=1 next cycle -> R_DATA.
REQ-038 SHALL on rvalid&rready with beat!=arlen load rdata<=mem[index+1] next cycle, rvalid held: one beat per cycle under continuous rready; rdata/rlast stable while rready=0.
REQ-039 SHALL assert rlast only on beat arlen; rvalid&rready&rlast -> R_IDLE, rvalid=0, arready=1 next cycle.
REQ-040 SHALL for arburst!=2'b01 return arlen+1 beats, rdata=0, rresp=2'b10; otherwise rresp=2'b00.
REQ-041 SHALL, if a write updates the word being fetched into rdata in the same cycle, return old contents (read-before-write).
REQ-042 SHALL handle awlen=0/arlen=0 as single beat, awlen=255 as 256 beats, bursts crossing top word wrap to index 0.

Reset
REQ-043 SHALL on rst_n=0, asynchronously, mid-burst included: FSMs to IDLE, awready=arready=1, wready=bvalid=rvalid=rlast=0, bid=rid=0, bresp=rresp=0, rdata=0; memory contents retained, not initialised.

Verification
REQ-044 SHALL verify write awaddr=0x40 awlen=3 data 1..4 strb 0xFF, read back -> rdata 1,2,3,4, rlast on beat 4, bresp/rresp 0.
REQ-045 SHALL verify strb 0x0F writing 0xAAAA_AAAA_AAAA_AAAA over 0x1111_1111_1111_1111 -> 0x1111_1111_AAAA_AAAA.
REQ-046 SHALL verify rready toggled 1,0,0,1 in an arlen=7 read -> rdata/rlast held during stalls, 8 beats in order, rid=awid echoed.
REQ-047 SHALL verify awburst=2'b10 and wlast early on beat 2 of awlen=3 -> bresp=2'b10, memory unchanged.
REQ-048 SHALL verify write burst at last word, awlen=1 -> second beat lands at index 0; rst_n pulse mid-read -> rvalid=0 asynchronously, arready=1.
